// File: rtl/intdiv_pkg.sv
// Shared types and elaboration helpers for the sequential restoring divider.
package intdiv_pkg;

  typedef enum logic [1:0] {StIdle, StIter, StDone} intdiv_state_e;

  function automatic int unsigned calc_lat(input int unsigned logc, input int unsigned bpc);
    return logc / bpc + 1;
  endfunction

  function automatic bit bpc_legal(input int unsigned logc, input int unsigned bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((logc % bpc) == 0);
  endfunction

endpackage

// File: rtl/intdiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module intdiv_step
  import intdiv_pkg::*;
#(
  parameter int unsigned LOGB = 60
) (
  input  logic [LOGB:0]   rem,
  input  logic            bit_in,
  input  logic [LOGB-1:0] divisor,
  output logic [LOGB:0]   rem_next,
  output logic            q_bit
);

  always_comb begin
    q_bit    = ({rem, bit_in} >= {2'b00, divisor});
    // The incoming remainder is always below the divisor, so the result fits in LOGB+1 bits.
    rem_next = (LOGB+1)'(q_bit ? ({rem, bit_in} - {2'b00, divisor}) : {rem, bit_in});
  end

endmodule

// File: rtl/intdiv_seq.sv
// Sequential restoring divider resolving BPC quotient bits per cycle, valid/ready on both sides.
module intdiv_seq
  import intdiv_pkg::*;
#(
  parameter int unsigned LOGB = 60,
  parameter int unsigned LOGC = 120,
  parameter int unsigned BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGC-1:0] C,
  input  logic [LOGB-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGC-1:0] Q,
  output logic [LOGB-1:0] R,
  output logic            DZ
);

  localparam int unsigned LAT   = calc_lat(LOGC, BPC);
  localparam int unsigned Iters = LAT - 1;
  localparam int unsigned CntW  = $clog2(Iters + 1);

  if (!bpc_legal(LOGC, BPC)) begin : g_bpc_check
    $error("intdiv_seq: BPC must be 1, 2 or 4 and must divide LOGC");
  end

  intdiv_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LOGC-1:0] quo_q, quo_d;
  logic [LOGB:0]   rem_q, rem_d;
  logic [LOGB-1:0] div_q, div_d;
  logic [LOGC-1:0] q_q, q_d;
  logic [LOGB-1:0] r_q, r_d;
  logic            dz_q, dz_d;

  for (genvar j = 0; j < BPC; j++) begin : g_step
    logic [LOGB:0]   rem_in, rem_out;
    logic [LOGC-1:0] quo_in, quo_out;
    logic            qb;

    if (j == 0) begin : g_first
      assign rem_in = rem_q;
      assign quo_in = quo_q;
    end else begin : g_next
      assign rem_in = g_step[j-1].rem_out;
      assign quo_in = g_step[j-1].quo_out;
    end

    intdiv_step #(
      .LOGB (LOGB)
    ) u_step (
      .rem      (rem_in),
      .bit_in   (quo_in[LOGC-1]),
      .divisor  (div_q),
      .rem_next (rem_out),
      .q_bit    (qb)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign quo_out = {quo_in[LOGC-2:0], qb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          quo_d = C;
          div_d = B;
          rem_d = '0;
          cnt_d = CntW'(Iters);
          if (B == '0) begin
            state_d = StDone;
            q_d     = '1;
            r_d     = C[LOGB-1:0];
            dz_d    = 1'b1;
          end else begin
            state_d = StIter;
          end
        end
      end
      StIter: begin
        quo_d = g_step[BPC-1].quo_out;
        rem_d = g_step[BPC-1].rem_out;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          q_d     = g_step[BPC-1].quo_out;
          r_d     = g_step[BPC-1].rem_out[LOGB-1:0];
          dz_d    = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Q  = q_q;
  assign R  = r_q;
  assign DZ = dz_q;

endmodule
